// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the fetch scheduler and its hazard scoreboard.
//   - opcode constants for the three decoded instruction classes
//   - bit positions of the opcode and register fields
//   - FSM state type for the scheduler
//   - decode helper that returns the registers read/written by one word
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000111;
    localparam logic [5:0] OP_LOAD  = 6'b001000;
    localparam logic [5:0] OP_STORE = 6'b001001;

    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned RS_MSB  = 25;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_MSB  = 20;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_MSB  = 15;
    localparam int unsigned RD_LSB  = 11;
    // Lowest instruction bit that decode looks at.
    localparam int unsigned DEC_LSB = RD_LSB;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fsm_state_e;

    typedef struct packed {
        logic                 rs_rd;   // rs is a source operand
        logic                 rt_rd;   // rt is a source operand
        logic                 wr;      // instruction writes wreg
        logic [REG_IDX_W-1:0] rs;
        logic [REG_IDX_W-1:0] rt;
        logic [REG_IDX_W-1:0] wreg;
    } decode_t;

    // Takes only the bits that carry opcode and register fields.
    function automatic decode_t decode(input logic [31:DEC_LSB] w);
        decode_t d;
        d      = '0;
        d.rs   = w[RS_MSB:RS_LSB];
        d.rt   = w[RT_MSB:RT_LSB];
        case (w[OP_MSB:OP_LSB])
            OP_RTYPE: begin
                d.rs_rd = 1'b1;
                d.rt_rd = 1'b1;
                d.wr    = 1'b1;
                d.wreg  = w[RD_MSB:RD_LSB];
            end
            OP_LOAD: begin
                d.rs_rd = 1'b1;
                d.wr    = 1'b1;
                d.wreg  = w[RT_MSB:RT_LSB];
            end
            OP_STORE: begin
                d.rs_rd = 1'b1;
                d.rt_rd = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register down-counters guarding read-after-write.
// A counter is loaded with HAZARD_CYCLES when a writer of that register
// issues and otherwise counts down to 0; a non-zero counter blocks readers.
// All 32 registers are tracked, r0 included.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   wr_en, wr_reg      write port: writer issuing this cycle
//   rd0_en, rd0_reg    read-check port 0 (rs)
//   rd1_en, rd1_reg    read-check port 1 (rt)
//   rd0_busy, rd1_busy read-check result: register still in flight
//   all_clear          every counter is 0
module hazard_scoreboard
    import mips_pkg::*;
#(
    parameter int unsigned HAZARD_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_reg,
    input  logic                 rd0_en,
    input  logic [REG_IDX_W-1:0] rd0_reg,
    input  logic                 rd1_en,
    input  logic [REG_IDX_W-1:0] rd1_reg,
    output logic                 rd0_busy,
    output logic                 rd1_busy,
    output logic                 all_clear
);

    localparam int unsigned CW = (HAZARD_CYCLES > 0) ? $clog2(HAZARD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(HAZARD_CYCLES);

    logic [NUM_REGS-1:0][CW-1:0] cnt_q, cnt_d;

    // Reload wins over the decrement of the same counter.
    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_en && (wr_reg == REG_IDX_W'(i))) begin
                cnt_d[i] = LOAD_VAL;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rd0_busy  = rd0_en && (cnt_q[rd0_reg] != '0);
    assign rd1_busy  = rd1_en && (cnt_q[rd1_reg] != '0);
    assign all_clear = (cnt_q == '0);

endmodule

// File: rtl/fetch_scheduler.sv
// fetch_scheduler: fetches a program from a synchronous-read instruction
// memory and issues it in order, inserting bubbles while a source register
// is still within HAZARD_CYCLES of its last issued writer.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          one-cycle pulse starting a run (ignored unless idle)
//   prog_len       instruction count, sampled on an accepted start
//   imem_addr      word address to instruction memory
//   imem_data      memory word, valid one cycle after its address
//   issue_ready    downstream accepts an instruction this cycle
//   instr_out      issued instruction (0 when nothing issues)
//   instr_valid    instr_out issues this cycle
//   stall          held word blocked by the scoreboard
//   busy           run in progress
//   done           one-cycle end-of-run pulse
//   stall_count    (FETCH_SCHED_STATS_EN only) saturating stall-cycle count,
//                  cleared on accepted start and on reset
// Build option: define FETCH_SCHED_STATS_EN to add stall_count.
module fetch_scheduler
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned HAZARD_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] prog_len,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  issue_ready,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic                  instr_valid,
    output logic                  stall,
    output logic                  busy,
    output logic                  done
`ifdef FETCH_SCHED_STATS_EN
    ,
    output logic [15:0]           stall_count
`endif
);

    fsm_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] last_pc;

    decode_t dec;
    logic    rd0_busy, rd1_busy, all_clear, hazard;

    // The memory output is the held word: keeping imem_addr at the PC
    // re-reads the same word, so no separate holding register is needed.
    assign dec     = decode(imem_data[31:DEC_LSB]);
    assign hazard  = rd0_busy || rd1_busy;
    assign last_pc = len_q - ADDR_WIDTH'(1);

    hazard_scoreboard #(
        .HAZARD_CYCLES(HAZARD_CYCLES)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (instr_valid && dec.wr),
        .wr_reg   (dec.wreg),
        .rd0_en   (dec.rs_rd),
        .rd0_reg  (dec.rs),
        .rd1_en   (dec.rt_rd),
        .rd1_reg  (dec.rt),
        .rd0_busy (rd0_busy),
        .rd1_busy (rd1_busy),
        .all_clear(all_clear)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        len_d       = len_q;
        imem_addr   = pc_q;
        instr_valid = 1'b0;
        stall       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = prog_len;
                    pc_d    = '0;
                    state_d = (prog_len == '0) ? ST_DONE : ST_PRIME;
                end
            end
            ST_PRIME: begin
                // pc_q is 0 here, so word 0 is presented to memory.
                busy    = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                busy        = 1'b1;
                stall       = hazard;
                instr_valid = !hazard && issue_ready;
                if (instr_valid) begin
                    if (pc_q == last_pc) begin
                        state_d = ST_DRAIN;
                    end else begin
                        // Prefetch the next word so it is held next cycle.
                        pc_d      = pc_q + ADDR_WIDTH'(1);
                        imem_addr = pc_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (all_clear) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign instr_out = instr_valid ? imem_data : '0;

`ifdef FETCH_SCHED_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_IDLE) && start) begin
            stall_cnt_d = '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_scheduler.sv
// Bench for fetch_scheduler: dut_a uses HAZARD_CYCLES=3, dut_b uses 0.
// Stimulus pushes expected (cycle, word) issues and done cycles into
// queues; negedge monitors pop and compare whenever the DUTs present them.
module tb_fetch_scheduler;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    // LOAD rt,0(r31): base register r31 is never written.
    localparam logic [31:0] W_L0   = 32'h23E00000;
    localparam logic [31:0] W_L1   = 32'h23E10000;
    localparam logic [31:0] W_L2   = 32'h23E20000;
    localparam logic [31:0] W_L3   = 32'h23E30000;
    localparam logic [31:0] W_SUB4 = 32'h1C202022; // r4 = r1 - r0
    localparam logic [31:0] W_SUB5 = 32'h1C432822; // r5 = r2 - r3
    localparam logic [31:0] W_MUL6 = 32'h1C853018; // r6 = r4 * r5
    localparam logic [31:0] W_ST6  = 32'h27E60000; // store r6,0(r31)
    localparam logic [31:0] W_PAD  = 32'h23F40000; // load r20,0(r31)

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          start_b = 1'b0;
    logic          issue_ready = 1'b1;
    logic [AW-1:0] prog_len = '0;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a = '0, data_b = '0;
    logic [DW-1:0] out_a, out_b;
    logic          valid_a, stall_a, busy_a, done_a;
    logic          valid_b, stall_b, busy_b, done_b;
`ifdef FETCH_SCHED_STATS_EN
    logic [15:0]   scount_a, scount_b;
`endif

    logic [DW-1:0] mem [0:1023];

    logic [31:0] base_w [0:7] = '{W_L0, W_L1, W_L2, W_L3, W_SUB4, W_SUB5, W_MUL6, W_ST6};
    int unsigned base_rel [0:7] = '{0, 1, 2, 3, 5, 7, 11, 15};
    logic [31:0] pad_w [0:17] = '{W_L0, W_L1, W_L2, W_L3, W_PAD, W_SUB4, W_PAD, W_SUB5,
                                  W_PAD, W_PAD, W_PAD, W_MUL6, W_PAD, W_PAD, W_PAD,
                                  W_ST6, W_PAD, W_PAD};

    typedef struct {
        int unsigned cyc;
        logic [31:0] word;
    } exp_t;

    exp_t        q_a[$], q_b[$];
    int unsigned dq_a[$], dq_b[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned stalls_a = 0;
    int unsigned stalls_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        data_a <= mem[addr_a];
        data_b <= mem[addr_b];
    end

    fetch_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HAZARD_CYCLES(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
        .imem_addr(addr_a), .imem_data(data_a), .issue_ready(issue_ready),
        .instr_out(out_a), .instr_valid(valid_a), .stall(stall_a),
        .busy(busy_a), .done(done_a)
`ifdef FETCH_SCHED_STATS_EN
        , .stall_count(scount_a)
`endif
    );

    fetch_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HAZARD_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .prog_len(prog_len),
        .imem_addr(addr_b), .imem_data(data_b), .issue_ready(issue_ready),
        .instr_out(out_b), .instr_valid(valid_b), .stall(stall_b),
        .busy(busy_b), .done(done_b)
`ifdef FETCH_SCHED_STATS_EN
        , .stall_count(scount_b)
`endif
    );

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        exp_t e;
        if (stall_a) stalls_a++;
        if (stall_b) stalls_b++;
        if (valid_a) begin
            check("a_issue_expected", (q_a.size() != 0) ? 1 : 0, 1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                check("a_issue_word", out_a, e.word);
                check("a_issue_cycle", cyc, e.cyc);
            end
        end
        if (valid_b) begin
            check("b_issue_expected", (q_b.size() != 0) ? 1 : 0, 1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                check("b_issue_word", out_b, e.word);
                check("b_issue_cycle", cyc, e.cyc);
            end
        end
        if (done_a) begin
            check("a_done_expected", (dq_a.size() != 0) ? 1 : 0, 1);
            if (dq_a.size() != 0) check("a_done_cycle", cyc, dq_a.pop_front());
        end
        if (done_b) begin
            check("b_done_expected", (dq_b.size() != 0) ? 1 : 0, 1);
            if (dq_b.size() != 0) check("b_done_cycle", cyc, dq_b.pop_front());
        end
    end

    task automatic load_base();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 8; i++) mem[i] = base_w[i];
    endtask

    task automatic load_pad();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 18; i++) mem[i] = pad_w[i];
    endtask

    task automatic goto_cycle(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input bit sel_b, input logic [AW-1:0] len);
        prog_len = len;
        if (sel_b) start_b = 1'b1;
        else start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_drain(input bit sel_b, input int unsigned budget, input string name);
        int unsigned k = 0;
        int unsigned left;
        left = sel_b ? (q_b.size() + dq_b.size()) : (q_a.size() + dq_a.size());
        while (k < budget && left != 0) begin
            @(negedge clk);
            #1;
            k++;
            left = sel_b ? (q_b.size() + dq_b.size()) : (q_a.size() + dq_a.size());
        end
        check(name, left, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic push_base_a(input int unsigned s);
        for (int i = 0; i < 8; i++) q_a.push_back('{s + 2 + base_rel[i], base_w[i]});
        dq_a.push_back(s + 19);
    endtask

    initial begin
        int unsigned s;
        int unsigned st0;

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s;
        int unsigned st0;

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_imem_addr", addr_a, 0);
        check("rst_instr_out", out_a, 0);
        check("rst_instr_valid", valid_a, 0);
        check("rst_stall", stall_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_busy_b", busy_b, 0);
`ifdef FETCH_SCHED_STATS_EN
        check("rst_stall_count", scount_a, 0);
`endif
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Base program with hazards; a start mid-run must be ignored.
        load_base();
        st0 = stalls_a;
        s = cyc;
        push_base_a(s);
        do_start(0, 10'd8);
        goto_cycle(s + 6);
        start = 1'b1;
        prog_len = 10'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain(0, 60, "base_drain");
        check("base_stall_cycles", stalls_a - st0, 8);
`ifdef FETCH_SCHED_STATS_EN
        check("base_stall_count", scount_a, 8);
`endif

        // Padded program: no hazards, 18 back-to-back issues.
        load_pad();
        st0 = stalls_a;
        s = cyc;
        for (int i = 0; i < 18; i++) q_a.push_back('{s + 2 + i, pad_w[i]});
        dq_a.push_back(s + 24);
        do_start(0, 10'd18);
        wait_drain(0, 60, "pad_drain");
        check("pad_stall_cycles", stalls_a - st0, 0);
`ifdef FETCH_SCHED_STATS_EN
        check("pad_stall_count", scount_a, 0);
`endif

        // issue_ready low for 5 cycles after word 5 issues.
        st0 = stalls_a;
        s = cyc;
        for (int i = 0; i < 18; i++)
            q_a.push_back('{s + 2 + ((i < 6) ? i : i + 5), pad_w[i]});
        dq_a.push_back(s + 29);
        do_start(0, 10'd18);
        goto_cycle(s + 8);
        issue_ready = 1'b0;
        goto_cycle(s + 10);
        check("ready_low_pc_frozen", addr_a, 6);
        check("ready_low_no_stall", stall_a, 0);
        goto_cycle(s + 13);
        issue_ready = 1'b1;
        wait_drain(0, 60, "ready_drain");
        check("ready_stall_cycles", stalls_a - st0, 0);

        // Reset two cycles after start, then restart from word 0.
        load_base();
        s = cyc;
        do_start(0, 10'd8);
        goto_cycle(s + 2);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", valid_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_addr", addr_a, 0);
        goto_cycle(s + 4);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_idle_busy", busy_a, 0);
        st0 = stalls_a;
        s = cyc;
        push_base_a(s);
        do_start(0, 10'd8);
        wait_drain(0, 60, "restart_drain");
        check("restart_stall_cycles", stalls_a - st0, 8);

        // prog_len == 0: done one cycle after start, nothing issues.
        s = cyc;
        dq_a.push_back(s + 1);
        do_start(0, 10'd0);
        wait_drain(0, 10, "zero_len_drain");
        repeat (3) @(posedge clk);
        #1;
        check("zero_len_busy", busy_a, 0);

        // HAZARD_CYCLES = 0: all eight words back to back.
        load_base();
        s = cyc;
        for (int i = 0; i < 8; i++) q_b.push_back('{s + 2 + i, base_w[i]});
        dq_b.push_back(s + 11);
        do_start(1, 10'd8);
        wait_drain(1, 40, "h0_drain");
        check("h0_stall_cycles", stalls_b, 0);
`ifdef FETCH_SCHED_STATS_EN
        check("h0_stall_count", scount_b, 0);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
